// File: rtl/fcvt_s_w_pkg.sv
// Shared float-unit definitions for the integer-to-binary32 converter.
//   - rounding-mode encodings RM_RNE..RM_RMM (codes 5-7 behave as RNE)
//   - binary32 field positions and exponent bias
//   - FSM state encoding for fcvt_s_w
package fcvt_s_w_pkg;

    localparam logic [2:0] RM_RNE = 3'd0;
    localparam logic [2:0] RM_RTZ = 3'd1;
    localparam logic [2:0] RM_RDN = 3'd2;
    localparam logic [2:0] RM_RUP = 3'd3;
    localparam logic [2:0] RM_RMM = 3'd4;

    localparam int FP32_SIGN_BIT = 31;
    localparam int FP32_EXP_MSB  = 30;
    localparam int FP32_EXP_LSB  = 23;
    localparam int FP32_FRAC_MSB = 22;
    localparam int FP32_EXP_W    = FP32_EXP_MSB - FP32_EXP_LSB + 1;
    localparam int FP32_FRAC_W   = FP32_FRAC_MSB + 1;
    localparam int EXP_BIAS      = 127;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ABS   = 3'd1,
        ST_NORM  = 3'd2,
        ST_ROUND = 3'd3,
        ST_DONE  = 3'd4
    } cvt_state_e;

endpackage

// File: rtl/fcvt_s_w_round_inc.sv
// fp32_round_inc: decides whether the truncated significand must be
// incremented by one ulp.
//   sign : sign of the result
//   lsb  : least significant kept fraction bit
//   g    : first discarded bit (guard)
//   st   : OR of all remaining discarded bits (sticky)
//   rm   : rounding mode (5-7 fall back to RNE)
//   inc  : 1 = add one ulp to the kept significand
module fp32_round_inc
    import fcvt_s_w_pkg::*;
(
    input  logic       sign,
    input  logic       lsb,
    input  logic       g,
    input  logic       st,
    input  logic [2:0] rm,
    output logic       inc
);

    always_comb begin
        inc = g & (st | lsb);
        case (rm)
            RM_RTZ:  inc = 1'b0;
            RM_RDN:  inc = sign & (g | st);
            RM_RUP:  inc = ~sign & (g | st);
            RM_RMM:  inc = g;
            default: inc = g & (st | lsb);
        endcase
    end

endmodule

// File: rtl/fcvt_s_w.sv
// fcvt_s_w: multi-cycle FCVT.S.W / FCVT.S.WU (32-bit integer -> binary32).
//   clk         : clock, all state updates on the rising edge
//   resetn      : synchronous reset, active high
//   start       : request, only honoured in IDLE
//   rs1         : integer operand (captured on start)
//   is_unsigned : 1 = unsigned operand, 0 = two's complement
//   rm          : rounding mode (captured on start)
//   busy        : high from the cycle after start until the done cycle
//   done        : one-cycle pulse, out/nx valid
//   out         : binary32 result, held until the next done
//   nx          : inexact flag belonging to out
//
// Handshake: start is a request qualified only while idle; there is no
// back-pressure, and done is a single-cycle strobe that the consumer must
// take when it appears. out/nx stay stable between strobes.
//
// Flow: IDLE -> ABS -> NORM x NORM_STAGES -> ROUND -> DONE -> IDLE.
// The current FSM state is visible as the signal `state` for checkers.
module fcvt_s_w
    import fcvt_s_w_pkg::*;
#(
    parameter int NORM_STAGES = 5
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        start,
    input  logic [31:0] rs1,
    input  logic        is_unsigned,
    input  logic [2:0]  rm,
    output logic        busy,
    output logic        done,
    output logic [31:0] out,
    output logic        nx
);

    // Exponent of a value whose leading one sits at bit 31 before any shift.
    localparam logic [7:0] EXP_TOP   = 8'(EXP_BIAS + 31);
    localparam logic [2:0] LAST_STEP = 3'(NORM_STAGES - 1);

    cvt_state_e state, state_next;

    logic [2:0]  step;
    logic [31:0] op;
    logic        uns_q;
    logic [2:0]  rm_q;
    logic        sign_q;
    logic        zero_q;
    logic [31:0] mag;
    logic [5:0]  sh;

    // ABS datapath
    logic        sign_w;
    logic [31:0] abs_w;

    assign sign_w = ~uns_q & op[31];
    assign abs_w  = sign_w ? (~op + 32'd1) : op;

    // NORM datapath: step k tests the top (16>>k) bits for all-zero.
    logic [4:0]  amt;
    logic [31:0] top_mask;
    logic        top_clear;

    assign amt       = 5'd16 >> step;
    assign top_mask  = ~(32'hFFFF_FFFF >> amt);
    assign top_clear = (mag & top_mask) == 32'd0;

    // ROUND datapath: exponent and fraction are added as one field so a
    // fraction carry-out bumps the exponent (2^32 lands on exponent 159).
    logic [FP32_EXP_W-1:0]            exp_w;
    logic                             g_w;
    logic                             st_w;
    logic                             inc_w;
    logic [FP32_EXP_W+FP32_FRAC_W-1:0] rounded;

    assign exp_w   = EXP_TOP - {2'b00, sh};
    assign g_w     = mag[7];
    assign st_w    = |mag[6:0];
    assign rounded = {exp_w, mag[30:8]} + {30'd0, inc_w};

    fp32_round_inc u_round_inc (
        .sign (sign_q),
        .lsb  (mag[8]),
        .g    (g_w),
        .st   (st_w),
        .rm   (rm_q),
        .inc  (inc_w)
    );

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:  if (start) state_next = ST_ABS;
            ST_ABS:   state_next = ST_NORM;
            ST_NORM:  if (step == LAST_STEP) state_next = ST_ROUND;
            ST_ROUND: state_next = ST_DONE;
            ST_DONE:  state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (resetn) begin
            state  <= ST_IDLE;
            step   <= 3'd0;
            op     <= 32'd0;
            uns_q  <= 1'b0;
            rm_q   <= 3'd0;
            sign_q <= 1'b0;
            zero_q <= 1'b0;
            mag    <= 32'd0;
            sh     <= 6'd0;
            out    <= 32'd0;
            nx     <= 1'b0;
        end else begin
            state <= state_next;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        op    <= rs1;
                        uns_q <= is_unsigned;
                        rm_q  <= rm;
                    end
                end
                ST_ABS: begin
                    sign_q <= sign_w;
                    mag    <= abs_w;
                    zero_q <= (abs_w == 32'd0);
                    sh     <= 6'd0;
                    step   <= 3'd0;
                end
                ST_NORM: begin
                    if (top_clear) begin
                        mag <= mag << amt;
                        sh  <= sh + {1'b0, amt};
                    end
                    step <= step + 3'd1;
                end
                ST_ROUND: begin
                    // Zero input gives +0.0 regardless of rounding mode.
                    if (zero_q) begin
                        out <= 32'd0;
                        nx  <= 1'b0;
                    end else begin
                        out[FP32_SIGN_BIT]               <= sign_q;
                        out[FP32_EXP_MSB:FP32_EXP_LSB]   <= rounded[30:23];
                        out[FP32_FRAC_MSB:0]             <= rounded[22:0];
                        nx                               <= g_w | st_w;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy = (state != ST_IDLE);
    assign done = (state == ST_DONE);

endmodule

// File: tb/tb_fcvt_s_w.sv
module tb_fcvt_s_w;

    logic        clk = 1'b0;
    logic        resetn;
    logic        start;
    logic [31:0] rs1;
    logic        is_unsigned;
    logic [2:0]  rm;
    logic        busy;
    logic        done;
    logic [31:0] out;
    logic        nx;

    int n_checks = 0;
    int pass_cnt = 0;
    int fail_cnt = 0;

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    fcvt_s_w dut (
        .clk         (clk),
        .resetn      (resetn),
        .start       (start),
        .rs1         (rs1),
        .is_unsigned (is_unsigned),
        .rm          (rm),
        .busy        (busy),
        .done        (done),
        .out         (out),
        .nx          (nx)
    );

    // ---------------- scoreboard ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference model: exact magnitude, locate leading one, drop the bits
    // below a 24-bit significand and round by comparing the remainder to
    // half an ulp.
    function automatic void model(input logic [31:0] a, input bit uns, input logic [2:0] m,
                                  output logic [31:0] r, output logic x);
        bit               s;
        longint unsigned  mg, q, rem, half;
        int               p, drop, mode;
        bit               inc;
        logic [7:0]       e;
        s  = !uns && a[31];
        mg = s ? (64'h1_0000_0000 - longint'(a)) : longint'(a);
        r  = 32'd0;
        x  = 1'b0;
        if (mg == 0) return;
        p = 0;
        for (int i = 0; i < 33; i++) if (mg[i]) p = i;
        rem  = 0;
        half = 0;
        if (p <= 23) begin
            q = mg << (23 - p);
        end else begin
            drop = p - 23;
            q    = mg >> drop;
            rem  = mg & ((64'd1 << drop) - 1);
            half = 64'd1 << (drop - 1);
        end
        mode = (m > 3'd4) ? 0 : int'(m);
        inc  = 1'b0;
        if (rem != 0) begin
            case (mode)
                0: inc = (rem > half) || (rem == half && q[0]);
                1: inc = 1'b0;
                2: inc = s;
                3: inc = !s;
                default: inc = (rem >= half);
            endcase
        end
        q = q + longint'(inc);
        if (q == (64'd1 << 24)) begin
            q = q >> 1;
            p++;
        end
        e = 8'(127 + p);
        r = {s, e, q[22:0]};
        x = (rem != 0);
    endfunction

    // ---------------- driver ----------------
    // Issues one conversion and follows it to done; checks busy every
    // cycle, that out holds mid-flight, the latency and the idle return.
    task automatic convert(input logic [31:0] a, input bit uns, input logic [2:0] m,
                           output logic [31:0] r, output logic x);
        logic [31:0] prev_out;
        int          lat;
        @(negedge clk);
        rs1 = a; is_unsigned = uns; rm = m; start = 1'b1;
        prev_out = out;
        lat = 0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (k == 1) begin
                start = 1'b0;
                rs1 = $urandom;
                is_unsigned = ~uns;
                rm = 3'($urandom_range(0, 7));
            end
            if (k == 4) check("out_hold", out, prev_out);
            check("busy_run", {31'd0, busy}, 32'd1);
            if (done) begin
                lat = k;
                break;
            end
        end
        check("latency", lat, 8);
        r = out;
        x = nx;
        @(negedge clk);
        check("done_pulse", {31'd0, done}, 32'd0);
        check("busy_idle", {31'd0, busy}, 32'd0);
    endtask

    task automatic conv_check(input string tag, input logic [31:0] a, input bit uns,
                              input logic [2:0] m, input logic [31:0] exp_r, input logic exp_x);
        logic [31:0] r;
        logic        x;
        convert(a, uns, m, r, x);
        check({tag, "_out"}, r, exp_r);
        check({tag, "_nx"}, {31'd0, x}, {31'd0, exp_x});
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [31:0] r, er, a;
        logic        x, ex;
        bit          u;
        logic [2:0]  m;
        int          dones;

        resetn = 1'b1; start = 1'b0; rs1 = 32'd0; is_unsigned = 1'b0; rm = 3'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        resetn = 1'b0;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_out", out, 32'd0);
        check("rst_nx", {31'd0, nx}, 32'd0);

        // directed conversions
        conv_check("one_w_rne",   32'h0000_0001, 1'b0, 3'd0, 32'h3F80_0000, 1'b0);
        conv_check("m1_w_rne",    32'hFFFF_FFFF, 1'b0, 3'd0, 32'hBF80_0000, 1'b0);
        conv_check("max_wu_rne",  32'hFFFF_FFFF, 1'b1, 3'd0, 32'h4F80_0000, 1'b1);
        conv_check("imax_rne",    32'h7FFF_FFFF, 1'b0, 3'd0, 32'h4F00_0000, 1'b1);
        conv_check("imax_rtz",    32'h7FFF_FFFF, 1'b0, 3'd1, 32'h4EFF_FFFF, 1'b1);
        conv_check("tie_rne",     32'h0100_0001, 1'b0, 3'd0, 32'h4B80_0000, 1'b1);
        conv_check("tie_rup",     32'h0100_0001, 1'b0, 3'd3, 32'h4B80_0001, 1'b1);
        conv_check("tie_rmm",     32'h0100_0001, 1'b0, 3'd4, 32'h4B80_0001, 1'b1);
        conv_check("tie_rdn",     32'h0100_0001, 1'b0, 3'd2, 32'h4B80_0000, 1'b1);
        conv_check("imin_w",      32'h8000_0000, 1'b0, 3'd0, 32'hCF00_0000, 1'b0);
        conv_check("zero_rdn",    32'h0000_0000, 1'b0, 3'd2, 32'h0000_0000, 1'b0);
        conv_check("neg_tie_rdn", 32'hFEFF_FFFF, 1'b0, 3'd2, 32'hCB80_0001, 1'b1);
        conv_check("rm7_as_rne",  32'h0100_0003, 1'b0, 3'd7, 32'h4B80_0002, 1'b1);

        // second start while busy (held through the DONE cycle) is ignored
        @(negedge clk);
        rs1 = 32'd3; is_unsigned = 1'b0; rm = 3'd0; start = 1'b1;
        dones = 0;
        for (int k = 1; k <= 25; k++) begin
            @(negedge clk);
            if (k == 1) begin start = 1'b0; rs1 = 32'd5; end
            if (k == 3) start = 1'b1;
            if (k == 9) start = 1'b0;
            if (done) dones++;
        end
        check("ignored_start_dones", dones, 1);
        check("ignored_start_out", out, 32'h4040_0000);

        // reset mid-operation aborts without a done
        @(negedge clk);
        rs1 = 32'd100; start = 1'b1;
        dones = 0;
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            if (k == 1) start = 1'b0;
            if (k == 4) resetn = 1'b1;
            if (k == 5) begin
                resetn = 1'b0;
                check("abort_busy", {31'd0, busy}, 32'd0);
                check("abort_out", out, 32'd0);
                check("abort_nx", {31'd0, nx}, 32'd0);
            end
            if (done) dones++;
        end
        check("abort_dones", dones, 0);
        conv_check("after_reset", 32'd6, 1'b0, 3'd0, 32'h40C0_0000, 1'b0);

        // randomized conversions against the reference model
        for (int i = 0; i < 60; i++) begin
            case ($urandom_range(0, 3))
                0: a = $urandom;
                1: a = 32'($urandom_range(0, 300));
                2: a = (32'd1 << $urandom_range(0, 31)) | ($urandom & 32'h1FF);
                default: a = ~32'($urandom_range(0, 300));
            endcase
            u = 1'($urandom_range(0, 1));
            m = 3'($urandom_range(0, 7));
            model(a, u, m, er, ex);
            convert(a, u, m, r, x);
            check("rand_out", r, er);
            check("rand_nx", {31'd0, x}, {31'd0, ex});
        end

        $display("%0d/%0d checks passed", pass_cnt, n_checks);
        $finish;
    end

endmodule
